// File: rtl/dm_unit.sv
// M-stage data memory: byte/half/word stores into a word array, extended loads, sticky error flags, store counter.
// Optional store trace is enabled by defining DM_TRACE_EN.
module dm_unit #(
    parameter int WORDS  = 4096,
    parameter int ADDR_W = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IR_M,
    input  logic [31:0] PC_M,
    input  logic        DMWr,
    input  logic [31:0] Addr,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic        ErrAlign,
    output logic        ErrRange,
    output logic [31:0] StCnt
);

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;

    logic [31:0]       mem_q [WORDS];
    logic              err_align_q, err_align_d;
    logic              err_range_q, err_range_d;
    logic [31:0]       stcnt_q, stcnt_d;

    logic [5:0]        opcode;
    logic [ADDR_W-1:0] idx;
    logic [1:0]        off;
    logic              range_ok;
    logic              is_load, is_store_op;
    logic              ld_byte, ld_half, ld_signed;
    logic              st_byte, st_half;
    logic              ld_aligned, st_aligned;
    logic              commit, align_err, range_err;
    logic [3:0]        byte_mask;
    logic [31:0]       bit_mask, rep_data, cur_word, mem_wdata_d, shifted;
    logic [15:0]       half_v;

    assign opcode   = IR_M[31:26];
    assign idx      = Addr[ADDR_W+1:2];
    assign off      = Addr[1:0];
    assign range_ok = (Addr[31:ADDR_W+2] == '0);
    assign cur_word = mem_q[idx];

    always_comb begin
        is_load     = 1'b0;
        is_store_op = 1'b0;
        ld_byte     = 1'b0;
        ld_half     = 1'b0;
        ld_signed   = 1'b0;
        st_byte     = 1'b0;
        st_half     = 1'b0;
        case (opcode)
            OP_LW:  is_load = 1'b1;
            OP_LB:  begin is_load = 1'b1; ld_byte = 1'b1; ld_signed = 1'b1; end
            OP_LBU: begin is_load = 1'b1; ld_byte = 1'b1; end
            OP_LH:  begin is_load = 1'b1; ld_half = 1'b1; ld_signed = 1'b1; end
            OP_LHU: begin is_load = 1'b1; ld_half = 1'b1; end
            OP_SW:  is_store_op = 1'b1;
            OP_SB:  begin is_store_op = 1'b1; st_byte = 1'b1; end
            OP_SH:  begin is_store_op = 1'b1; st_half = 1'b1; end
            default: ;
        endcase
    end

    assign ld_aligned = ld_byte | (ld_half ? ~Addr[0] : (off == 2'b00));
    assign st_aligned = st_byte | (st_half ? ~Addr[0] : (off == 2'b00));

    // Any DMWr commits as some store; only real store opcodes may flag errors.
    assign commit    = DMWr & st_aligned & range_ok;
    assign align_err = (DMWr & is_store_op & ~st_aligned) | (~DMWr & is_load & ~ld_aligned);
    assign range_err = ((DMWr & is_store_op) | (~DMWr & is_load)) & ~range_ok;

    always_comb begin
        byte_mask = 4'b1111;
        rep_data  = WD;
        if (st_byte) begin
            byte_mask = 4'b0001 << off;
            rep_data  = {4{WD[7:0]}};
        end else if (st_half) begin
            byte_mask = Addr[1] ? 4'b1100 : 4'b0011;
            rep_data  = {2{WD[15:0]}};
        end
        bit_mask = '0;
        for (int i = 0; i < 4; i++) begin
            bit_mask[8*i +: 8] = {8{byte_mask[i]}};
        end
        mem_wdata_d = (cur_word & ~bit_mask) | (rep_data & bit_mask);
    end

    always_comb begin
        shifted = cur_word >> {off, 3'b000};
        half_v  = Addr[1] ? cur_word[31:16] : cur_word[15:0];
        RD      = '0;
        if (is_load && ld_aligned && range_ok) begin
            if (ld_byte) begin
                RD = {{24{ld_signed & shifted[7]}}, shifted[7:0]};
            end else if (ld_half) begin
                RD = {{16{ld_signed & half_v[15]}}, half_v};
            end else begin
                RD = cur_word;
            end
        end
    end

    always_comb begin
        err_align_d = err_align_q | align_err;
        err_range_d = err_range_q | range_err;
        stcnt_d     = stcnt_q + 32'(commit);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < WORDS; i++) begin
                mem_q[i] <= '0;
            end
            err_align_q <= 1'b0;
            err_range_q <= 1'b0;
            stcnt_q     <= '0;
        end else begin
            if (commit) begin
                mem_q[idx] <= mem_wdata_d;
            end
            err_align_q <= err_align_d;
            err_range_q <= err_range_d;
            stcnt_q     <= stcnt_d;
        end
    end

    assign ErrAlign = err_align_q;
    assign ErrRange = err_range_q;
    assign StCnt    = stcnt_q;

`ifdef DM_TRACE_EN
    always_ff @(posedge clk) begin
        if (!reset && commit) begin
            $display("@%h: *%h <= %h", PC_M, {Addr[31:2], 2'b00}, mem_wdata_d);
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^PC_M;
`endif

    logic unused_ir;
    assign unused_ir = ^IR_M[25:0];

endmodule

// File: tb/tb_dm_unit.sv
// Self-checking bench for dm_unit: directed plan scenarios plus randomized traffic
// against a byte-addressed reference memory.
module tb_dm_unit;

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_NOP = 6'b000000;
    localparam logic [31:0] MEM_BYTES = 32'h4000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] IR_M, PC_M, Addr, WD;
    logic        DMWr;
    logic [31:0] RD, StCnt;
    logic        ErrAlign, ErrRange;

    int checks = 0;
    int errors = 0;

    logic [7:0]  model_mem [16384];
    bit          m_align, m_range;
    logic [31:0] m_cnt;

    dm_unit dut (
        .clk(clk), .reset(reset), .IR_M(IR_M), .PC_M(PC_M), .DMWr(DMWr),
        .Addr(Addr), .WD(WD), .RD(RD), .ErrAlign(ErrAlign), .ErrRange(ErrRange),
        .StCnt(StCnt)
    );

    always #5 clk = ~clk;

    function automatic int size_of(input logic [5:0] op);
        if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
        if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
        return 4;
    endfunction

    function automatic bit is_ld(input logic [5:0] op);
        return op inside {OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU};
    endfunction

    function automatic logic [31:0] m_load(input logic [5:0] op, input logic [31:0] addr);
        int size;
        logic [31:0] v;
        if (!is_ld(op)) return 32'h0;
        size = size_of(op);
        if (addr >= MEM_BYTES || (addr % 32'(size)) != 0) return 32'h0;
        v = 32'h0;
        for (int i = 0; i < size; i++) v = v | (32'(model_mem[addr + 32'(i)]) << (8 * i));
        if ((op == OP_LB || op == OP_LH) && v[8*size-1]) v = v | ~((32'd1 << (8 * size)) - 32'd1);
        return v;
    endfunction

    task automatic m_edge();
        logic [5:0] op;
        int size;
        bit inr, al;
        op = IR_M[31:26];
        if (reset) begin
            for (int i = 0; i < 16384; i++) model_mem[i] = 8'h00;
            m_align = 0;
            m_range = 0;
            m_cnt = 32'h0;
            return;
        end
        inr = Addr < MEM_BYTES;
        size = size_of(op);
        al = (Addr % 32'(size)) == 0;
        if (DMWr) begin
            if (op inside {OP_SW, OP_SB, OP_SH}) begin
                if (!al) m_align = 1;
                if (!inr) m_range = 1;
            end else begin
                size = 4;
                al = (Addr % 32'd4) == 0;
            end
            if (al && inr) begin
                for (int i = 0; i < size; i++) model_mem[Addr + 32'(i)] = WD[8*i +: 8];
                m_cnt = m_cnt + 32'd1;
            end
        end else if (is_ld(op)) begin
            if (!al) m_align = 1;
            if (!inr) m_range = 1;
        end
    endtask

    task automatic drive(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         input logic wr, input logic rst);
        IR_M  = {op, 26'($urandom)};
        PC_M  = $urandom;
        Addr  = addr;
        WD    = wd;
        DMWr  = wr;
        reset = rst;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        m_edge();
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] a;
        drive(OP_NOP, 0, 0, 0, 1);
        tick();
        drive(OP_NOP, 0, 0, 0, 0);
        checks++; if (ErrAlign !== 1'b0) begin errors++; $display("FAIL reset_erralign got %b exp 0", ErrAlign); end
        checks++; if (ErrRange !== 1'b0) begin errors++; $display("FAIL reset_errrange got %b exp 0", ErrRange); end
        checks++; if (StCnt !== 32'h0) begin errors++; $display("FAIL reset_stcnt got %h exp 0", StCnt); end
        for (int i = 0; i < 4; i++) begin
            a = {18'h0, 12'($urandom), 2'b00};
            drive(OP_LW, a, 0, 0, 0);
            checks++; if (RD !== 32'h0) begin errors++; $display("FAIL reset_rd addr %h got %h exp 0", a, RD); end
        end
    endtask

    task automatic test_word_byte_half();
        drive(OP_SW, 32'h10, 32'h12345678, 1, 0); tick();
        checks++; if (StCnt !== 32'd1) begin errors++; $display("FAIL sw_stcnt got %h exp 1", StCnt); end
        drive(OP_LW, 32'h10, 0, 0, 0);
        checks++; if (RD !== 32'h12345678) begin errors++; $display("FAIL lw_word got %h exp 12345678", RD); end
        tick();
        drive(OP_SB, 32'h11, 32'hFFFFFFAB, 1, 0); tick();
        drive(OP_LW, 32'h10, 0, 0, 0);
        checks++; if (RD !== 32'h1234AB78) begin errors++; $display("FAIL sb_merge got %h exp 1234ab78", RD); end
        drive(OP_LB, 32'h11, 0, 0, 0);
        checks++; if (RD !== 32'hFFFFFFAB) begin errors++; $display("FAIL lb_sext got %h exp ffffffab", RD); end
        drive(OP_LBU, 32'h11, 0, 0, 0);
        checks++; if (RD !== 32'h000000AB) begin errors++; $display("FAIL lbu_zext got %h exp 000000ab", RD); end
        tick();
        drive(OP_SH, 32'h12, 32'h00008001, 1, 0); tick();
        drive(OP_LW, 32'h10, 0, 0, 0);
        checks++; if (RD !== 32'h8001AB78) begin errors++; $display("FAIL sh_merge got %h exp 8001ab78", RD); end
        drive(OP_LH, 32'h12, 0, 0, 0);
        checks++; if (RD !== 32'hFFFF8001) begin errors++; $display("FAIL lh_sext got %h exp ffff8001", RD); end
        drive(OP_LHU, 32'h12, 0, 0, 0);
        checks++; if (RD !== 32'h00008001) begin errors++; $display("FAIL lhu_zext got %h exp 00008001", RD); end
        tick();
        checks++; if (StCnt !== 32'd3) begin errors++; $display("FAIL stcnt_three got %h exp 3", StCnt); end
    endtask

    task automatic test_misaligned();
        drive(OP_SW, 32'h22, 32'hCAFEF00D, 1, 0); tick();
        drive(OP_LW, 32'h20, 0, 0, 0);
        checks++; if (RD !== 32'h0) begin errors++; $display("FAIL misal_mem got %h exp 0", RD); end
        checks++; if (StCnt !== 32'd3) begin errors++; $display("FAIL misal_stcnt got %h exp 3", StCnt); end
        checks++; if (ErrAlign !== 1'b1) begin errors++; $display("FAIL misal_flag got %b exp 1", ErrAlign); end
        checks++; if (ErrRange !== 1'b0) begin errors++; $display("FAIL misal_range got %b exp 0", ErrRange); end
        drive(OP_LH, 32'h13, 0, 0, 0);
        checks++; if (RD !== 32'h0) begin errors++; $display("FAIL misal_lh got %h exp 0", RD); end
        tick();
        drive(OP_NOP, 0, 0, 0, 0); tick(); tick();
        checks++; if (ErrAlign !== 1'b1) begin errors++; $display("FAIL misal_sticky got %b exp 1", ErrAlign); end
    endtask

    task automatic test_range();
        drive(OP_SW, 32'h4000, 32'h11111111, 1, 0); tick();
        checks++; if (ErrRange !== 1'b1) begin errors++; $display("FAIL range_flag got %b exp 1", ErrRange); end
        checks++; if (StCnt !== 32'd3) begin errors++; $display("FAIL range_stcnt got %h exp 3", StCnt); end
        drive(OP_SW, 32'h3FFC, 32'hDEADBEEF, 1, 0); tick();
        drive(OP_LW, 32'h3FFC, 0, 0, 0);
        checks++; if (RD !== 32'hDEADBEEF) begin errors++; $display("FAIL range_top got %h exp deadbeef", RD); end
        drive(OP_LW, 32'h4000, 0, 0, 0);
        checks++; if (RD !== 32'h0) begin errors++; $display("FAIL range_ld got %h exp 0", RD); end
        drive(OP_LW, 32'h0, 0, 0, 0);
        checks++; if (RD !== 32'h0) begin errors++; $display("FAIL range_alias got %h exp 0", RD); end
        tick();
    endtask

    task automatic test_reset_mid_op();
        drive(OP_SW, 32'h10, 32'hA5A5A5A5, 1, 1); tick();
        drive(OP_LW, 32'h10, 0, 0, 0);
        checks++; if (RD !== 32'h0) begin errors++; $display("FAIL rstmid_rd got %h exp 0", RD); end
        checks++; if (StCnt !== 32'h0) begin errors++; $display("FAIL rstmid_stcnt got %h exp 0", StCnt); end
        checks++; if (ErrAlign !== 1'b0 || ErrRange !== 1'b0) begin
            errors++; $display("FAIL rstmid_flags got %b%b exp 00", ErrAlign, ErrRange);
        end
        drive(OP_LW, 32'h3FFC, 0, 0, 0);
        checks++; if (RD !== 32'h0) begin errors++; $display("FAIL rstmid_top got %h exp 0", RD); end
        tick();
    endtask

    task automatic test_random();
        logic [5:0] ops [9] = '{OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_SW, OP_SB, OP_SH, OP_NOP};
        logic [5:0] op;
        logic [31:0] a, exp_rd;
        logic wr, rst;
        int r;
        for (int n = 0; n < 400; n++) begin
            op = ops[$urandom_range(0, 8)];
            wr = (op inside {OP_SW, OP_SB, OP_SH}) ? 1'b1 : ($urandom_range(0, 19) == 0);
            rst = ($urandom_range(0, 99) == 0);
            r = $urandom_range(0, 9);
            if (r < 8) a = 32'($urandom_range(0, 63));
            else if (r == 8) a = 32'h3FE0 + 32'($urandom_range(0, 63));
            else a = $urandom;
            drive(op, a, $urandom, wr, rst);
            exp_rd = m_load(op, a);
            checks++; if (RD !== exp_rd) begin
                errors++; $display("FAIL rand_rd op %b addr %h got %h exp %h", op, a, RD, exp_rd);
            end
            tick();
            checks++; if (ErrAlign !== m_align || ErrRange !== m_range || StCnt !== m_cnt) begin
                errors++;
                $display("FAIL rand_state got %b %b %h exp %b %b %h",
                         ErrAlign, ErrRange, StCnt, m_align, m_range, m_cnt);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_rd;
        for (int i = 0; i < 4; i++) begin
            drive(OP_SB, 32'h30 + 32'(i), $urandom, 1, 0); tick();
        end
        drive(OP_SH, 32'h32, $urandom, 1, 0); tick();
        for (int a = 0; a < 64; a += 4) begin
            drive(OP_LW, 32'(a), 0, 0, 0);
            exp_rd = m_load(OP_LW, 32'(a));
            checks++; if (RD !== exp_rd) begin
                errors++; $display("FAIL sweep addr %h got %h exp %h", a, RD, exp_rd);
            end
        end
        tick();
        checks++; if (StCnt !== m_cnt) begin errors++; $display("FAIL b2b_stcnt got %h exp %h", StCnt, m_cnt); end
    endtask

    initial begin
        reset = 1'b1; DMWr = 1'b0; IR_M = '0; PC_M = '0; Addr = '0; WD = '0;
        m_align = 0; m_range = 0; m_cnt = 32'h0;
        test_reset();
        test_word_byte_half();
        test_misaligned();
        test_range();
        test_reset_mid_op();
        test_random();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dm_unit.md
Name: dm_unit

Overview:
- M-stage data memory responder for the P6 pipelined MIPS CPU.
- Consumes the write strobe and instruction word of the instruction in M, and performs byte/half/word stores into a word-organised array.
- Returns sign- or zero-extended load data for W-stage write-back on the DR path.
- Tracks misaligned and out-of-range accesses in sticky error flags and counts committed stores.

Parameters:
- WORDS, 4096, number of 32-bit words in the array.
- ADDR_W, 12, word-index width; log2(WORDS).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- IR_M  input  32  instruction in M; opcode IR_M[31:26] selects access size and extension.
- PC_M  input  32  PC of the M instruction; used only by the optional trace.
- DMWr  input  1  store strobe from the M-stage controller.
- Addr  input  32  byte address (ALU output of M).
- WD  input  32  store data (forwarded rt value, right-aligned).
- RD  output  32  extended load data, combinational.
- ErrAlign  output  1  sticky flag: misaligned access seen.
- ErrRange  output  1  sticky flag: out-of-range access seen.
- StCnt  output  32  count of committed stores.

Behaviour:
- Opcode decode:
  - lw 100011, lb 100000, lbu 100100, lh 100001, lhu 100101.
  - sw 101011, sb 101000, sh 101001.
  - Any other opcode is a non-access.
- Word index: idx = Addr[ADDR_W+1:2]; byte offset = Addr[1:0].
- Range check: range_ok when Addr[31:ADDR_W+2] == 0.
- Alignment:
  - Word accesses require offset 00.
  - Half accesses require Addr[0]=0.
  - Byte accesses are always aligned.
- Store, when DMWr=1:
  - Byte mask from opcode: sb gives a one-hot mask at offset; sh gives 0011 or 1100 by Addr[1]; any other opcode gives 1111.
  - WD[7:0] is replicated to the selected byte for sb; WD[15:0] to the selected half for sh.
  - Unselected bytes of mem[idx] are preserved.
  - A store commits only when aligned and range_ok; it updates mem[idx] at the rising edge; StCnt increments by 1 in the same edge.
  - StCnt wraps from 0xFFFFFFFF to 0.
- Load (RD), purely combinational from the current mem[idx]; no added latency, result valid in the same cycle as Addr:
  - lb/lbu select the byte at offset; lh/lhu select the half at Addr[1]; lw selects the word.
  - lb/lh are sign-extended; lbu/lhu are zero-extended.
  - RD = 0 when the access is misaligned or out of range, or the opcode is not a load.
- Same-cycle ordering: a load reads the pre-edge contents. Load and store never coexist in one instruction.
- Error flags:
  - On a misaligned load or store (store only when DMWr=1), ErrAlign is set at the next edge.
  - On an out-of-range access, ErrRange is set at the next edge.
  - Both flags stay set until reset.
  - An access that is both misaligned and out of range sets both flags.
- Reset, at the edge with reset=1:
  - All WORDS entries are cleared to 0.
  - ErrAlign=0, ErrRange=0, StCnt=0.
  - Reset has priority over a concurrent store, including mid-stream resets.
  - Post-reset RD = 0 for every address.
- DMWr=1 with a load opcode: treated as a full-word store (controller misuse); no error is raised.

Optional Feature:
- Macro: DM_TRACE_EN.
- Defined:
  - Each committed store prints "@%h: *%h <= %h" at the edge, giving PC_M, the word-aligned address ({Addr[31:2],2'b00}), and the merged 32-bit word written.
  - Suppressed stores print nothing.
- Undefined: no display statements are compiled; behaviour is otherwise identical.

Test Plan:
- Store/load word: reset; sw Addr=0x10, WD=0x12345678 -> lw Addr=0x10 RD=0x12345678; StCnt=1.
- Byte store: after the above, sb Addr=0x11, WD=0xFFFFFFAB -> lw 0x10 RD=0x1234AB78; lb 0x11 RD=0xFFFFFFAB; lbu 0x11 RD=0x000000AB.
- Half store: sh Addr=0x12, WD=0x00008001 -> lw 0x10 RD=0x8001AB78; lh 0x12 RD=0xFFFF8001; lhu 0x12 RD=0x00008001.
- Misaligned: sw Addr=0x22, DMWr=1 -> mem unchanged, StCnt unchanged, ErrAlign=1 next cycle and held; lh Addr=0x13 -> RD=0.
- Range: WORDS=4096; sw Addr=0x4000 -> suppressed, ErrRange=1; lw Addr=0x3FFC after sw 0x3FFC of 0xDEADBEEF -> RD=0xDEADBEEF.
- Reset mid-op: reset=1 together with sw 0x10 WD=0xA5A5A5A5 -> lw 0x10 RD=0, StCnt=0, both flags 0; trace (DM_TRACE_EN) prints nothing for that edge.
